sigma_csr_periph: RTL and testbench

SIGMA_CSR_PERIPH -- requirements
Module: sigma_csr_periph

---
 rtl/sigma_csr_pkg.sv | 32 +++
 rtl/sigma_sync.sv | 29 ++
 rtl/sigma_csr_periph.sv | 168 ++++++++++++++++
 tb/tb_sigma_csr_periph.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_csr_pkg.sv
// Shared constants for the sigma CSR peripheral: register offsets, timer
// control bit positions, identification value and byte-lane helpers.
package sigma_csr_pkg;

  localparam logic [4:0] OFF_LED       = 5'h00;
  localparam logic [4:0] OFF_SW        = 5'h04;
  localparam logic [4:0] OFF_SW_EDGE   = 5'h08;
  localparam logic [4:0] OFF_SW_IRQ_EN = 5'h0C;
  localparam logic [4:0] OFF_TMR_CNT   = 5'h10;
  localparam logic [4:0] OFF_TMR_CMP   = 5'h14;
  localparam logic [4:0] OFF_TMR_CTRL  = 5'h18;
  localparam logic [4:0] OFF_ID        = 5'h1C;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AR   = 1;
  localparam int CTRL_PEND = 2;
  localparam int CTRL_IE   = 3;

  localparam logic [31:0] ID_VALUE    = 32'h5C5A0001;
  localparam logic [31:0] TMR_CMP_RST = 32'hFFFFFFFF;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/sigma_sync.sv
// Multi-flop synchronizer bringing an asynchronous bus into the clk_i domain.
module sigma_sync #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], d_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sigma_csr_periph.sv
// GPIO + timer CSR slave on the xif bus: LED/switch registers with edge
// capture, a compare timer, and a registered level interrupt.
module sigma_csr_periph
  import sigma_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h80000000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_bi,
  input  logic [3:0]  be_bi,
  input  logic [31:0] wdata_bi,
  output logic        ack_o,
  output logic        resp_o,
  output logic [31:0] rdata_bo,
  input  logic [31:0] gpio_bi,
  output logic [31:0] gpio_bo,
  output logic        irq_o
);

  localparam logic [2:0] VLD_MAX = 3'(SYNC_STAGES + 1);

  logic        hit, wr_en, rd_en;
  logic [2:0]  widx;
  logic [31:0] wmask;
  logic        wr_led, wr_edge, wr_irqen, wr_cnt, wr_cmp, wr_ctrl, wr_ctrl_b0;
  logic [31:0] sw_sync, rd_mux, edge_set;
  logic        sw_vld, match, match_eff;
  logic        unused_addr_lsb;

  logic [31:0] led_q, led_d;
  logic [31:0] sw_irq_en_q, sw_irq_en_d;
  logic [31:0] sw_edge_q, sw_edge_d;
  logic [31:0] sw_prev_q, sw_prev_d;
  logic [2:0]  vld_cnt_q, vld_cnt_d;
  logic [31:0] tmr_cnt_q, tmr_cnt_d;
  logic [31:0] tmr_cmp_q, tmr_cmp_d;
  logic        en_q, en_d, ar_q, ar_d, pend_q, pend_d, ie_q, ie_d;
  logic        resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  sigma_sync #(
    .WIDTH(32),
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (gpio_bi),
    .q_o   (sw_sync)
  );

  // Word-granular decode; the byte offset within a word is irrelevant.
  assign unused_addr_lsb = ^addr_bi[1:0];
  assign hit   = req_i && (addr_bi[31:5] == BASE_ADDR[31:5]);
  assign widx  = addr_bi[4:2];
  assign wr_en = hit && we_i;
  assign rd_en = hit && !we_i;
  assign ack_o = req_i;
  assign wmask = be_mask(be_bi);

  assign wr_led     = wr_en && (widx == OFF_LED[4:2]);
  assign wr_edge    = wr_en && (widx == OFF_SW_EDGE[4:2]);
  assign wr_irqen   = wr_en && (widx == OFF_SW_IRQ_EN[4:2]);
  assign wr_cnt     = wr_en && (widx == OFF_TMR_CNT[4:2]);
  assign wr_cmp     = wr_en && (widx == OFF_TMR_CMP[4:2]);
  assign wr_ctrl    = wr_en && (widx == OFF_TMR_CTRL[4:2]);
  assign wr_ctrl_b0 = wr_ctrl && be_bi[0];

  always_comb begin
    rd_mux = '0;
    case (widx)
      OFF_LED[4:2]:       rd_mux = led_q;
      OFF_SW[4:2]:        rd_mux = sw_sync;
      OFF_SW_EDGE[4:2]:   rd_mux = sw_edge_q;
      OFF_SW_IRQ_EN[4:2]: rd_mux = sw_irq_en_q;
      OFF_TMR_CNT[4:2]:   rd_mux = tmr_cnt_q;
      OFF_TMR_CMP[4:2]:   rd_mux = tmr_cmp_q;
      OFF_TMR_CTRL[4:2]:  rd_mux = {28'd0, ie_q, pend_q, ar_q, en_q};
      OFF_ID[4:2]:        rd_mux = ID_VALUE;
      default:            rd_mux = '0;
    endcase
  end

  always_comb begin
    resp_d      = rd_en;
    rdata_d     = rd_en ? rd_mux : '0;
    led_d       = wr_led   ? byte_merge(led_q, wdata_bi, wmask)       : led_q;
    sw_irq_en_d = wr_irqen ? byte_merge(sw_irq_en_q, wdata_bi, wmask) : sw_irq_en_q;
    tmr_cmp_d   = wr_cmp   ? byte_merge(tmr_cmp_q, wdata_bi, wmask)   : tmr_cmp_q;

    // The previous-sample flop only becomes trustworthy once real switch
    // data has propagated through the synchronizer and into sw_prev_q.
    sw_prev_d = sw_sync;
    sw_vld    = (vld_cnt_q == VLD_MAX);
    vld_cnt_d = sw_vld ? vld_cnt_q : vld_cnt_q + 3'd1;
    edge_set  = sw_vld ? (sw_sync ^ sw_prev_q) : '0;
    sw_edge_d = (sw_edge_q & ~(wr_edge ? (wdata_bi & wmask) : 32'd0)) | edge_set;

    // A software write to the counter cancels a coincident match entirely.
    match     = en_q && (tmr_cnt_q == tmr_cmp_q);
    match_eff = match && !wr_cnt;
    tmr_cnt_d = tmr_cnt_q;
    if (wr_cnt) begin
      tmr_cnt_d = byte_merge(tmr_cnt_q, wdata_bi, wmask);
    end else if (match) begin
      tmr_cnt_d = ar_q ? 32'd0 : tmr_cnt_q;
    end else if (en_q) begin
      tmr_cnt_d = tmr_cnt_q + 32'd1;
    end

    en_d = en_q;
    ar_d = ar_q;
    ie_d = ie_q;
    if (match_eff && !ar_q) en_d = 1'b0;
    if (wr_ctrl_b0) begin
      en_d = wdata_bi[CTRL_EN];
      ar_d = wdata_bi[CTRL_AR];
      ie_d = wdata_bi[CTRL_IE];
    end
    pend_d = (pend_q & ~(wr_ctrl_b0 && wdata_bi[CTRL_PEND])) | match_eff;

    irq_d = (|(sw_edge_q & sw_irq_en_q)) | (pend_q & ie_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      led_q       <= '0;
      sw_irq_en_q <= '0;
      sw_edge_q   <= '0;
      sw_prev_q   <= '0;
      vld_cnt_q   <= '0;
      tmr_cnt_q   <= '0;
      tmr_cmp_q   <= TMR_CMP_RST;
      en_q        <= 1'b0;
      ar_q        <= 1'b0;
      pend_q      <= 1'b0;
      ie_q        <= 1'b0;
      resp_q      <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      led_q       <= led_d;
      sw_irq_en_q <= sw_irq_en_d;
      sw_edge_q   <= sw_edge_d;
      sw_prev_q   <= sw_prev_d;
      vld_cnt_q   <= vld_cnt_d;
      tmr_cnt_q   <= tmr_cnt_d;
      tmr_cmp_q   <= tmr_cmp_d;
      en_q        <= en_d;
      ar_q        <= ar_d;
      pend_q      <= pend_d;
      ie_q        <= ie_d;
      resp_q      <= resp_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
    end
  end

  assign resp_o   = resp_q;
  assign rdata_bo = resp_q ? rdata_q : 32'd0;
  assign gpio_bo  = led_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_sigma_csr_periph.sv
// Directed bench for sigma_csr_periph: read expectations go through a
// scoreboard queue popped by a response monitor.
module tb_sigma_csr_periph;

  localparam logic [31:0] B  = 32'h80000000;
  localparam int          SS = 2;

  logic        clk = 1'b0;
  logic        rst_i, req_i, we_i;
  logic [31:0] addr_bi, wdata_bi, gpio_bi;
  logic [3:0]  be_bi;
  logic        ack_o, resp_o, irq_o;
  logic [31:0] rdata_bo, gpio_bo;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mon_exp;
  string       mon_name;

  sigma_csr_periph #(
    .BASE_ADDR(B),
    .SYNC_STAGES(SS)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_bi (addr_bi),
    .be_bi   (be_bi),
    .wdata_bi(wdata_bi),
    .ack_o   (ack_o),
    .resp_o  (resp_o),
    .rdata_bo(rdata_bo),
    .gpio_bi (gpio_bi),
    .gpio_bo (gpio_bo),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Response monitor: every resp_o must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (resp_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL resp_without_request: got rdata %h, expected no response", rdata_bo);
        end else begin
          mon_exp  = exp_q.pop_front();
          mon_name = name_q.pop_front();
          check(mon_name, rdata_bo, mon_exp);
        end
      end else begin
        check("rdata_idle_zero", rdata_bo, 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    req_i = 1'b1; we_i = 1'b1; addr_bi = a; be_bi = be; wdata_bi = d;
    @(posedge clk);
    #1;
    req_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
    req_i = 1'b1; we_i = 1'b0; addr_bi = a; be_bi = 4'hF;
    @(posedge clk);
    #1;
    req_i = 1'b0;
  endtask

  task automatic miss_read(input logic [31:0] a, input string nm);
    req_i = 1'b1; we_i = 1'b0; addr_bi = a; be_bi = 4'hF;
    #1;
    check({nm, "_ack"}, 32'(ack_o), 32'd1);
    @(posedge clk);
    #1;
    req_i = 1'b0;
    check({nm, "_no_resp"}, 32'(resp_o), 32'd0);
    check({nm, "_rdata"}, rdata_bo, 32'd0);
  endtask

  task automatic check_reset_regs(input string tag);
    bus_read(B + 32'h00, 32'h0, {tag, "_led"});
    bus_read(B + 32'h0C, 32'h0, {tag, "_sw_irq_en"});
    bus_read(B + 32'h10, 32'h0, {tag, "_tmr_cnt"});
    bus_read(B + 32'h14, 32'hFFFFFFFF, {tag, "_tmr_cmp"});
    bus_read(B + 32'h18, 32'h0, {tag, "_tmr_ctrl"});
    tick(6);
    bus_read(B + 32'h08, 32'h0, {tag, "_sw_edge"});
    bus_read(B + 32'h04, gpio_bi, {tag, "_sw"});
    check({tag, "_gpio_bo"}, gpio_bo, 32'd0);
    check({tag, "_irq"}, 32'(irq_o), 32'd0);
  endtask

  logic [31:0] cnt_seq [8] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 32'd1};
  logic [31:0] wrap_seq[4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'd1};
  int          k;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0;
    addr_bi = '0; be_bi = '0; wdata_bi = '0;
    gpio_bi = 32'h000000F0;
    tick(3);
    check("rst_gpio_bo", gpio_bo, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_resp", 32'(resp_o), 32'd0);
    check("rst_rdata", rdata_bo, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    tick(1);
    check("idle_ack", 32'(ack_o), 32'd0);
    check_reset_regs("post_rst");

    // LED byte-enable writes
    bus_write(B, 4'b0011, 32'hA5A5A5A5);
    check("led_gpio_bo", gpio_bo, 32'h0000A5A5);
    bus_read(B, 32'h0000A5A5, "led_rd");
    bus_write(B, 4'b1000, 32'h12345678);
    bus_read(B + 32'h2, 32'h1200A5A5, "led_rd_be3");

    // RO writes ignored, ID, misses
    bus_write(B + 32'h1C, 4'hF, 32'h0);
    bus_write(B + 32'h04, 4'hF, 32'hFFFFFFFF);
    bus_read(B + 32'h1F, 32'h5C5A0001, "id_rd");
    bus_read(B + 32'h04, 32'h000000F0, "sw_ro_rd");
    miss_read(32'h80000020, "miss_hi");
    miss_read(32'h40000000, "miss_lo");

    // Switch edge interrupt
    bus_write(B + 32'h0C, 4'hF, 32'h8);
    gpio_bi = 32'h000000F8;
    for (k = 0; k < SS + 3 && !irq_o; k++) tick(1);
    check("sw_irq_rise", 32'(irq_o), 32'd1);
    bus_read(B + 32'h04, 32'h000000F8, "sw_rd");
    bus_read(B + 32'h08, 32'h00000008, "sw_edge_rd");
    bus_write(B + 32'h08, 4'hF, 32'h8);
    check("sw_irq_hold", 32'(irq_o), 32'd1);
    tick(1);
    check("sw_irq_fall", 32'(irq_o), 32'd0);
    bus_read(B + 32'h08, 32'h0, "sw_edge_cleared");

    // Autoreload timer, back-to-back counter reads
    bus_write(B + 32'h14, 4'hF, 32'd5);
    bus_write(B + 32'h18, 4'hF, 32'hB);
    for (int i = 0; i < 8; i++) bus_read(B + 32'h10, cnt_seq[i], $sformatf("tmr_ar_cnt%0d", i));
    bus_read(B + 32'h18, 32'hF, "tmr_ar_ctrl");
    check("tmr_irq_high", 32'(irq_o), 32'd1);
    bus_write(B + 32'h18, 4'hF, 32'h8);
    check("tmr_irq_held", 32'(irq_o), 32'd1);
    bus_write(B + 32'h18, 4'hF, 32'hC);
    check("tmr_irq_until_w1c", 32'(irq_o), 32'd1);
    tick(1);
    check("tmr_irq_fall", 32'(irq_o), 32'd0);
    bus_read(B + 32'h18, 32'h8, "tmr_ctrl_after_w1c");

    // One-shot timer
    bus_write(B + 32'h10, 4'hF, 32'd0);
    bus_write(B + 32'h14, 4'hF, 32'd3);
    bus_write(B + 32'h18, 4'hF, 32'h1);
    tick(8);
    bus_read(B + 32'h10, 32'd3, "oneshot_cnt");
    bus_read(B + 32'h18, 32'h4, "oneshot_ctrl");

    // Counter wrap
    bus_write(B + 32'h10, 4'hF, 32'hFFFFFFFE);
    bus_write(B + 32'h18, 4'hF, 32'h1);
    for (int i = 0; i < 4; i++) bus_read(B + 32'h10, wrap_seq[i], $sformatf("wrap_cnt%0d", i));
    bus_write(B + 32'h18, 4'hF, 32'h4);
    bus_read(B + 32'h18, 32'h0, "wrap_ctrl_stopped");

    // Counter write coincident with match: write wins, no PEND
    bus_write(B + 32'h18, 4'hF, 32'h1);
    bus_write(B + 32'h10, 4'hF, 32'h100);
    bus_read(B + 32'h18, 32'h1, "cnt_wr_vs_match_ctrl");
    bus_read(B + 32'h10, 32'h101, "cnt_wr_vs_match_cnt");
    bus_write(B + 32'h18, 4'hF, 32'h0);

    // Reset during a read request
    req_i = 1'b1; we_i = 1'b0; addr_bi = B; be_bi = 4'hF;
    #2;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    req_i = 1'b0;
    check("rstrd_resp0", 32'(resp_o), 32'd0);
    tick(2);
    check("rstrd_resp1", 32'(resp_o), 32'd0);
    check("rstrd_gpio_bo", gpio_bo, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    tick(1);
    check("rstrd_resp2", 32'(resp_o), 32'd0);
    check_reset_regs("rstrd");

    tick(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
